uart_rx_cfg: RTL



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_rx_cfg.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and baud divider helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Clocks per oversample tick; never below 1 so the counter stays legal.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned d;
        d = clk_freq / (baud * os);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator; tick is high while the divider sits at DIV-1.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    assign cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);

    // tick_q is registered from cnt_d so it is high exactly when cnt_q == DIV-1
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= (CNT_MAX == '0);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_MAX);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority voting,
// parity/framing/break/overrun status and a valid/ready holding register.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam int unsigned MID   = OVERSAMPLE / 2;

    localparam logic [OS_W-1:0]  OS_SM1  = OS_W'(MID - 1);
    localparam logic [OS_W-1:0]  OS_SM   = OS_W'(MID);
    localparam logic [OS_W-1:0]  OS_SP1  = OS_W'(MID + 1);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(DATA_BITS);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    logic tick;

    logic sync1_q;
    logic rxs_q;

    rx_state_e state_q, state_d;

    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 samp_a_q, samp_a_d;
    logic                 samp_b_q, samp_b_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 stop_low_q, stop_low_d;
    logic                 first_stop_q, first_stop_d;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 break_det_q;
    logic                 overrun_q;

    logic at_mid_c;
    logic at_end_c;
    logic maj_c;
    logic commit_c;
    logic first_stop_c;
    logic par_xor_c;
    logic parity_err_c;
    logic frame_err_c;
    logic break_c;

    uart_baud_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUDRATE   (BAUDRATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // rx is asynchronous; everything downstream uses rxs_q only
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    assign at_mid_c = tick && (os_cnt_q == OS_SP1);
    assign at_end_c = tick && (os_cnt_q == OS_LAST);
    assign maj_c    = (samp_a_q & samp_b_q) | (samp_a_q & rxs_q) | (samp_b_q & rxs_q);
    assign commit_c = (state_q == ST_STOP) && at_mid_c && (stop_idx_q == STOP_LAST);

    // Frame status as seen at the commit point (last stop bit's majority is live)
    assign first_stop_c = (stop_idx_q == 1'b0) ? maj_c : first_stop_q;
    assign par_xor_c    = (^shift_q) ^ par_bit_q;
    assign frame_err_c  = stop_low_q | ~maj_c;
    assign break_c      = (shift_q == '0) && ((PARITY == PAR_NONE) || !par_bit_q) && !first_stop_c;

    always_comb begin
        parity_err_c = 1'b0;
        if (PARITY == PAR_ODD) begin
            parity_err_c = ~par_xor_c;
        end else if (PARITY == PAR_EVEN) begin
            parity_err_c = par_xor_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxs_q) state_d = ST_START;
            end
            ST_START: begin
                if (at_mid_c && maj_c) state_d = ST_IDLE;
                else if (at_end_c)     state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_end_c && (idx_q == IDX_END)) begin
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_end_c) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (commit_c) state_d = maj_c ? ST_IDLE : ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit timing, sampling and frame datapath
    always_comb begin
        os_cnt_d     = os_cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        samp_a_d     = samp_a_q;
        samp_b_d     = samp_b_q;
        par_bit_d    = par_bit_q;
        stop_idx_d   = stop_idx_q;
        stop_low_d   = stop_low_q;
        first_stop_d = first_stop_q;

        if (tick) begin
            if (os_cnt_q == OS_SM1) samp_a_d = rxs_q;
            if (os_cnt_q == OS_SM)  samp_b_d = rxs_q;
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                os_cnt_d   = '0;
                idx_d      = '0;
                stop_idx_d = 1'b0;
                stop_low_d = 1'b0;
            end
            ST_DATA: begin
                if (at_mid_c) begin
                    shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_PARITY: begin
                if (at_mid_c) par_bit_d = maj_c;
            end
            ST_STOP: begin
                if (at_mid_c) begin
                    if (!maj_c) stop_low_d = 1'b1;
                    if (stop_idx_q == 1'b0) first_stop_d = maj_c;
                end
                if (at_end_c) stop_idx_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            os_cnt_q     <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            samp_a_q     <= 1'b1;
            samp_b_q     <= 1'b1;
            par_bit_q    <= 1'b0;
            stop_idx_q   <= 1'b0;
            stop_low_q   <= 1'b0;
            first_stop_q <= 1'b1;
        end else begin
            os_cnt_q     <= os_cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            samp_a_q     <= samp_a_d;
            samp_b_q     <= samp_b_d;
            par_bit_q    <= par_bit_d;
            stop_idx_q   <= stop_idx_d;
            stop_low_q   <= stop_low_d;
            first_stop_q <= first_stop_d;
        end
    end

    // Holding register: a commit against an unconsumed word is dropped and flagged
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (commit_c) begin
                if (rx_valid_q && !rx_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    rx_data_q    <= shift_q;
                    rx_valid_q   <= 1'b1;
                    parity_err_q <= parity_err_c;
                    frame_err_q  <= frame_err_c;
                    break_det_q  <= break_c;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule
